sparse_mvm_engine: RTL and testbench

- Parametrised, sparsity-aware signed matrix-vector multiply engine (y = A·x) for the tt_um_mvm datapath.
- Generalises the fixed-size MVM to configurable vector length, row count and data width.
- Adds a compressed sparse-row (CSR) input mode and a dense mode with zero-skipping.
- Loads x once per job into an internal register file, then consumes matrix beats and emits one accumulated result per row over a valid/ready stream.

---
 rtl/sparse_mvm_if.sv | 34 +++
 rtl/sparse_mvm_engine.sv | 165 ++++++++++++++++
 tb/tb_sparse_mvm_engine.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sparse_mvm_if.sv
// Stream bundle for the sparse MVM engine: x load, matrix beats and row results.
interface sparse_mvm_if #(
  parameter int unsigned DW   = 8,
  parameter int unsigned N    = 8,
  parameter int unsigned M    = 8,
  parameter int unsigned ACCW = 20,
  parameter int unsigned IW   = $clog2(N),
  parameter int unsigned RW   = (M > 1) ? $clog2(M) : 1
);
  logic            vec_valid;
  logic [DW-1:0]   vec_data;
  logic            vec_ready;
  logic            mat_valid;
  logic [DW-1:0]   mat_data;
  logic [IW-1:0]   mat_col;
  logic            mat_last;
  logic            mat_ready;
  logic            res_valid;
  logic [ACCW-1:0] res_data;
  logic [RW-1:0]   res_row;
  logic            res_ready;

  // Upstream/downstream side (feeds x and A, consumes results)
  modport master (
    output vec_valid, vec_data, mat_valid, mat_data, mat_col, mat_last, res_ready,
    input  vec_ready, mat_ready, res_valid, res_data, res_row
  );

  // Engine side
  modport slave (
    input  vec_valid, vec_data, mat_valid, mat_data, mat_col, mat_last, res_ready,
    output vec_ready, mat_ready, res_valid, res_data, res_row
  );
endinterface

// File: rtl/sparse_mvm_engine.sv
// Signed y = A*x engine with CSR and dense (zero-skipping) matrix input modes.
module sparse_mvm_engine #(
  parameter int unsigned DW   = 8,
  parameter int unsigned N    = 8,
  parameter int unsigned M    = 8,
  parameter int unsigned ACCW = 20,
  parameter int unsigned IW   = $clog2(N),
  parameter int unsigned RW   = (M > 1) ? $clog2(M) : 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cfg_dense,
  sparse_mvm_if.slave bus,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] skip_cnt
);

  localparam int unsigned PW = 2 * DW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic                   dense_q;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          col;
  logic [RW-1:0]          row;
  logic signed [ACCW-1:0] acc;
  logic signed [DW-1:0]   x_rf [N];

  logic                   vec_beat, mat_beat, res_beat;
  logic                   load_last, row_end, last_row;
  logic                   col_oob, zero_beat, mac_en;
  logic [IW-1:0]          csel;
  logic signed [DW-1:0]   x_sel;
  logic signed [DW-1:0]   a_val;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] acc_nxt;

  // Handshake qualifiers and row/column bookkeeping
  always_comb begin
    vec_beat  = (state == S_LOAD) && bus.vec_valid;
    mat_beat  = (state == S_COMPUTE) && bus.mat_valid;
    res_beat  = (state == S_OUT) && bus.res_ready;
    load_last = (idx == IW'(N - 1));
    last_row  = (row == RW'(M - 1));
    csel      = dense_q ? col : bus.mat_col;
    col_oob   = !dense_q && (32'(bus.mat_col) >= N);
    zero_beat = dense_q && (bus.mat_data == '0);
    row_end   = dense_q ? (col == IW'(N - 1)) : bus.mat_last;
    mac_en    = mat_beat && !zero_beat;
  end

  // Operand select; an out-of-range CSR column contributes nothing
  always_comb begin
    x_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (csel == IW'(i)) x_sel = x_rf[i];
    end
    if (col_oob) x_sel = '0;
  end

  // Full-width signed product, sign-extended into the wrapping accumulator
  always_comb begin
    a_val   = bus.mat_data;
    prod    = PW'(a_val) * PW'(x_sel);
    acc_nxt = mac_en ? (acc + ACCW'(prod)) : acc;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_LOAD;
      S_LOAD:    if (vec_beat && load_last) state_nxt = S_COMPUTE;
      S_COMPUTE: if (mat_beat && row_end) state_nxt = S_OUT;
      S_OUT:     if (res_beat) state_nxt = last_row ? S_IDLE : S_COMPUTE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Datapath, x register file and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      dense_q       <= 1'b0;
      idx           <= '0;
      col           <= '0;
      row           <= '0;
      acc           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      skip_cnt      <= '0;
      bus.vec_ready <= 1'b0;
      bus.mat_ready <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_row   <= '0;
      for (int unsigned i = 0; i < N; i++) x_rf[i] <= '0;
    end else begin
      bus.vec_ready <= (state_nxt == S_LOAD);
      bus.mat_ready <= (state_nxt == S_COMPUTE);
      bus.res_valid <= (state_nxt == S_OUT);
      busy          <= (state_nxt != S_IDLE);
      done          <= res_beat && last_row;
      case (state)
        S_IDLE: begin
          if (start) begin
            dense_q  <= cfg_dense;
            err      <= 1'b0;
            skip_cnt <= '0;
            row      <= '0;
            idx      <= '0;
          end
        end
        S_LOAD: begin
          if (vec_beat) begin
            for (int unsigned i = 0; i < N; i++) begin
              if (idx == IW'(i)) x_rf[i] <= bus.vec_data;
            end
            idx <= idx + IW'(1);
            if (load_last) begin
              acc <= '0;
              col <= '0;
            end
          end
        end
        S_COMPUTE: begin
          if (mat_beat) begin
            acc <= acc_nxt;
            col <= col + IW'(1);
            if (col_oob) err <= 1'b1;
            if (zero_beat && (skip_cnt != 16'hFFFF)) skip_cnt <= skip_cnt + 16'd1;
            if (row_end) begin
              bus.res_data <= acc_nxt;
              bus.res_row  <= row;
            end
          end
        end
        S_OUT: begin
          if (res_beat && !last_row) begin
            row <= row + RW'(1);
            acc <= '0;
            col <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_mvm_engine.sv
// Directed self-checking bench for sparse_mvm_engine (DW=8, N=5, M=4, ACCW=16).
module tb_sparse_mvm_engine;
  localparam int unsigned DW   = 8;
  localparam int unsigned N    = 5;
  localparam int unsigned M    = 4;
  localparam int unsigned ACCW = 16;
  localparam int unsigned IW   = $clog2(N);

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cfg_dense;
  logic        busy, done, err;
  logic [15:0] skip_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int xv [N];
  int rv [N];

  sparse_mvm_if #(.DW(DW), .N(N), .M(M), .ACCW(ACCW)) bus ();

  sparse_mvm_engine #(.DW(DW), .N(N), .M(M), .ACCW(ACCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_dense (cfg_dense),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .skip_cnt  (skip_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ACCW-1:0] r16(input int v);
    return v[ACCW-1:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic d);
    start     = 1'b1;
    cfg_dense = d;
    tick();
    start     = 1'b0;
  endtask

  task automatic load_vec;
    check("vec_ready_in_load", 32'(bus.vec_ready), 32'd1);
    for (int i = 0; i < int'(N); i++) begin
      bus.vec_valid = 1'b1;
      bus.vec_data  = DW'(xv[i]);
      tick();
    end
    bus.vec_valid = 1'b0;
  endtask

  task automatic send_beat(input int d, input int c, input logic last);
    int k;
    bus.mat_valid = 1'b1;
    bus.mat_data  = DW'(d);
    bus.mat_col   = IW'(c);
    bus.mat_last  = last;
    k = 0;
    while (!bus.mat_ready && k < 20) begin
      tick();
      k++;
    end
    if (!bus.mat_ready) check("mat_ready_timeout", 32'd0, 32'd1);
    tick();
    bus.mat_valid = 1'b0;
    bus.mat_last  = 1'b0;
  endtask

  task automatic dense_row;
    for (int i = 0; i < int'(N); i++) send_beat(rv[i], 0, 1'b0);
  endtask

  task automatic get_res(input string tag, input int d, input int row);
    int k;
    bus.res_ready = 1'b1;
    k = 0;
    while (!bus.res_valid && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.res_data), 32'(r16(d)));
    check({tag, "_row"}, 32'(bus.res_row), 32'(row));
    tick();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_dense = 1'b0;
    bus.vec_valid = 1'b0; bus.vec_data = '0;
    bus.mat_valid = 1'b0; bus.mat_data = '0; bus.mat_col = '0; bus.mat_last = 1'b0;
    bus.res_ready = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data",  32'(bus.res_data),  32'd0);
    check("rst_res_row",   32'(bus.res_row),   32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_done",      32'(done),          32'd0);
    check("rst_err",       32'(err),           32'd0);
    check("rst_skip",      32'(skip_cnt),      32'd0);
    check("rst_vec_ready", 32'(bus.vec_ready), 32'd0);
    check("rst_mat_ready", 32'(bus.mat_ready), 32'd0);
    rst = 1'b0;
    tick();

    // Dense identity with backpressure on row 1
    start_job(1'b1);
    check("t1_busy", 32'(busy), 32'd1);
    xv = '{1, 2, 3, 4, 5};
    load_vec();
    check("t1_mat_ready", 32'(bus.mat_ready), 32'd1);
    rv = '{1, 0, 0, 0, 0}; dense_row(); get_res("t1_r0", 1, 0);
    rv = '{0, 1, 0, 0, 0}; dense_row();
    for (int i = 0; i < 5; i++) begin
      bus.res_ready = 1'b0;
      bus.mat_valid = 1'b1;
      bus.mat_data  = DW'(7);
      check("bp_res_valid", 32'(bus.res_valid), 32'd1);
      check("bp_res_data",  32'(bus.res_data),  32'd2);
      check("bp_res_row",   32'(bus.res_row),   32'd1);
      check("bp_mat_ready", 32'(bus.mat_ready), 32'd0);
      check("bp_done",      32'(done),          32'd0);
      tick();
    end
    bus.mat_valid = 1'b0;
    get_res("t1_r1", 2, 1);
    rv = '{0, 0, 1, 0, 0}; dense_row(); get_res("t1_r2", 3, 2);
    rv = '{0, 0, 0, 1, 0}; dense_row(); get_res("t1_r3", 4, 3);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_skip", 32'(skip_cnt), 32'd16);

    // Signed CSR, started back-to-back with the done cycle
    start_job(1'b0);
    check("t2_done_drop", 32'(done), 32'd0);
    check("t2_skip_clr", 32'(skip_cnt), 32'd0);
    xv = '{-3, 5, 0, 7, 0};
    load_vec();
    send_beat(-2, 0, 1'b0); send_beat(4, 3, 1'b1);
    get_res("t2_r0", 34, 0);
    send_beat(127, 1, 1'b1);
    get_res("t2_r1", 635, 1);
    check("t2_err_before", 32'(err), 32'd0);
    send_beat(9, 5, 1'b1);
    check("t2_err_oob", 32'(err), 32'd1);
    get_res("t2_r2", 0, 2);
    send_beat(0, 0, 1'b1);
    get_res("t2_r3", 0, 3);
    check("t2_done", 32'(done), 32'd1);
    check("t2_err_sticky", 32'(err), 32'd1);
    check("t2_skip_csr", 32'(skip_cnt), 32'd0);
    tick();

    // Dense extremes: accumulator wraps modulo 2^16
    start_job(1'b1);
    check("t3_err_clr", 32'(err), 32'd0);
    xv = '{-128, -128, -128, -128, -128};
    load_vec();
    rv = '{-128, -128, -128, -128, 0};  dense_row(); get_res("t3_wrap0", 0, 0);
    rv = '{-128, -128, -128, -128, -128}; dense_row(); get_res("t3_wrap1", 16384, 1);
    rv = '{-1, 0, 0, 0, 0};              dense_row(); get_res("t3_r2", 128, 2);
    rv = '{127, 127, 0, 0, 0};           dense_row(); get_res("t3_r3", -32512, 3);
    check("t3_done", 32'(done), 32'd1);
    check("t3_skip", 32'(skip_cnt), 32'd8);
    tick();

    // Reset mid-COMPUTE aborts the job and clears x
    start_job(1'b0);
    xv = '{10, 20, 30, 40, 50};
    load_vec();
    send_beat(1, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_busy",      32'(busy),          32'd0);
    check("t4_res_valid", 32'(bus.res_valid), 32'd0);
    check("t4_mat_ready", 32'(bus.mat_ready), 32'd0);
    check("t4_done",      32'(done),          32'd0);
    check("t4_x_clr",     32'(dut.x_rf[2]),   32'd0);
    tick();

    // Fresh job; stray start and vec_valid in COMPUTE must be ignored
    start_job(1'b0);
    xv = '{2, 3, 4, 5, 6};
    load_vec();
    start = 1'b1; bus.vec_valid = 1'b1; bus.vec_data = DW'(99);
    tick();
    start = 1'b0; bus.vec_valid = 1'b0;
    check("t5_still_compute", 32'(bus.mat_ready), 32'd1);
    check("t5_vec_ready", 32'(bus.vec_ready), 32'd0);
    send_beat(1, 4, 1'b1);
    get_res("t5_r0", 6, 0);
    send_beat(2, 0, 1'b0); send_beat(-1, 1, 1'b0); send_beat(1, 2, 1'b0); send_beat(1, 3, 1'b1);
    get_res("t5_r1", 10, 1);
    send_beat(3, 2, 1'b1);
    get_res("t5_r2", 12, 2);
    send_beat(-1, 3, 1'b1);
    get_res("t5_r3", -5, 3);
    check("t5_done", 32'(done), 32'd1);
    tick();
    check("t5_done_pulse", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
